// File: rtl/decode_pkg.sv
// Shared constants and types for the decode stage: XLEN, register count,
// RV32I major opcodes, the immediate-format enum and the ID/EX record.
package decode_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Per-opcode usage summary
  typedef struct packed {
    logic legal;
    logic uses_rs1;
    logic uses_rs2;
    logic has_rd;
  } op_class_t;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              writes_rd;
    logic              illegal;
  } idex_t;

  // Which register fields an opcode reads/writes; unknown opcodes use nothing.
  function automatic op_class_t classify(input logic [6:0] opc);
    op_class_t c;
    c = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        c.legal = 1'b1; c.has_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        c.legal = 1'b1; c.uses_rs1 = 1'b1; c.has_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        c.legal = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        c.legal = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.has_rd = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Immediate layout selected by opcode; R-type and illegal carry none.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    imm_fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:                f = IMM_U;
      OPC_JAL:                           f = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:    f = IMM_I;
      OPC_STORE:                         f = IMM_S;
      OPC_BRANCH:                        f = IMM_B;
      default:                           f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: purely combinational immediate extraction, instr -> sign-extended imm.
module imm_gen
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  imm_fmt_e fmt;

  assign fmt = imm_fmt_of(instr[6:0]);

  // Reassemble the scattered immediate bits for the selected format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with a single ID/EX register and a 32-bit
// busy scoreboard for RAW/WAW interlocking.
// Optional feature macro: DECODE_BYPASS_EN -- when defined, a writeback in
// the same cycle satisfies a busy source and its data is captured directly.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  input  logic [XLEN-1:0]   DoutA,
  input  logic [XLEN-1:0]   DoutB,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic [XLEN-1:0]   wb_din,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_writes_rd,
  output logic              ex_illegal
);

  // Instruction fields
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  op_class_t         cls;
  logic              new_writes_rd;
  logic [XLEN-1:0]   imm;

  assign opcode        = if_instr[6:0];
  assign rd            = if_instr[11:7];
  assign rs1           = if_instr[19:15];
  assign rs2           = if_instr[24:20];
  assign cls           = classify(opcode);
  assign new_writes_rd = cls.has_rd && (rd != '0);

  // Register file is read asynchronously straight from the fetch word
  assign ra = rs1;
  assign rb = rs2;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // State
  logic                ex_valid_q, ex_valid_d;
  idex_t               idex_q, idex_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Writeback bypass selects
  logic byp1, byp2;

`ifdef DECODE_BYPASS_EN
  assign byp1 = wb_we && (wb_rw == rs1) && (rs1 != '0);
  assign byp2 = wb_we && (wb_rw == rs2) && (rs2 != '0);
`else
  // Without bypass, wb_din is only meaningful to the register file itself
  logic unused_wb_din;
  assign unused_wb_din = ^wb_din;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Hazard detection
  logic ex_hit_rs1, ex_hit_rs2, ex_hit_rd;
  logic raw1, raw2, waw, hazard;
  logic accept;
  logic sb_fire;

  assign ex_hit_rs1 = ex_valid_q && idex_q.writes_rd && (idex_q.rd == rs1);
  assign ex_hit_rs2 = ex_valid_q && idex_q.writes_rd && (idex_q.rd == rs2);
  assign ex_hit_rd  = ex_valid_q && idex_q.writes_rd && (idex_q.rd == rd);

  assign raw1   = cls.uses_rs1 && ((sb_q[rs1] && !byp1) || ex_hit_rs1);
  assign raw2   = cls.uses_rs2 && ((sb_q[rs2] && !byp2) || ex_hit_rs2);
  // WAW always waits for the older write to retire, bypass or not
  assign waw    = new_writes_rd && (sb_q[rd] || ex_hit_rd);
  assign hazard = raw1 || raw2 || waw;

  assign if_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  // A flushed entry is discarded, so it never marks its rd busy
  assign sb_fire = ex_valid_q && ex_ready && !flush && idex_q.writes_rd;

  // Operand selection: x0 is hardwired zero, bypass overrides the file
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == '0) ? '0 : (byp1 ? wb_din : DoutA);
  assign rs2_val = (rs2 == '0) ? '0 : (byp2 ? wb_din : DoutB);

  // Scoreboard next state per bit: set on ex handshake beats writeback clear
  logic [NUM_REGS-1:1] sb_set, sb_clr;
  assign sb_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      assign sb_set[gi] = sb_fire && (idex_q.rd == REG_AW'(gi));
      assign sb_clr[gi] = wb_we && (wb_rw == REG_AW'(gi));
      assign sb_d[gi]   = sb_set[gi] | (sb_q[gi] & ~sb_clr[gi]);
    end
  endgenerate

  // ID/EX next state: flush drops, accept loads, handshake empties, else hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    idex_d     = idex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d       = 1'b1;
      idex_d.pc        = if_pc;
      idex_d.rs1_val   = rs1_val;
      idex_d.rs2_val   = rs2_val;
      idex_d.imm       = imm;
      idex_d.rd        = rd;
      idex_d.opcode    = opcode;
      idex_d.funct3    = if_instr[14:12];
      idex_d.funct7    = if_instr[31:25];
      idex_d.writes_rd = new_writes_rd;
      idex_d.illegal   = !cls.legal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      idex_q     <= '0;
      sb_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      idex_q     <= idex_d;
      sb_q       <= sb_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_val   = idex_q.rs1_val;
  assign ex_rs2_val   = idex_q.rs2_val;
  assign ex_imm       = idex_q.imm;
  assign ex_rd        = idex_q.rd;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7    = idex_q.funct7;
  assign ex_writes_rd = idex_q.writes_rd;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage. Expected values are
// hand-computed from the instruction encodings; timing of writeback stalls
// follows DECODE_BYPASS_EN when it is defined for the build.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  ra, rb;
  logic [31:0] DoutA, DoutB;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_din;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_writes_rd, ex_illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Encodings
  localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X3     = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_BEQ_M8     = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] I_ILLEGAL    = 32'h0000_007F;
  localparam logic [31:0] I_ADDI_X5_7  = 32'h0070_0293;
  localparam logic [31:0] I_ADDI_X5_9  = 32'h0090_0293;
  localparam logic [31:0] I_ADD_X6     = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] I_ADDI_X0_1  = 32'h0010_0013;
  localparam logic [31:0] I_LUI_X7     = 32'h1234_53B7;
  localparam logic [31:0] I_ADD_X8     = 32'h0001_8433; // add x8,x3,x0

  decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .ra           (ra),
    .rb           (rb),
    .DoutA        (DoutA),
    .DoutB        (DoutB),
    .wb_we        (wb_we),
    .wb_rw        (wb_rw),
    .wb_din       (wb_din),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_pc        (ex_pc),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7    (ex_funct7),
    .ex_writes_rd (ex_writes_rd),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  // Instruction is stalled on a busy source; retire it through writeback.
  // With bypass it goes the same cycle; otherwise the cycle after, reading
  // the updated register file.
  task automatic wb_release(input string tag, input logic [4:0] rw, input logic [31:0] din,
                            input bit set_b);
    wb_we  = 1'b1;
    wb_rw  = rw;
    wb_din = din;
    #1;
`ifdef DECODE_BYPASS_EN
    check({tag, "_ready_on_wb"}, 32'(if_ready), 32'd1);
    tick();
    wb_we = 1'b0;
`else
    check({tag, "_stall_on_wb"}, 32'(if_ready), 32'd0);
    tick();
    wb_we = 1'b0;
    DoutA = din;
    if (set_b) DoutB = din;
    #1;
    check({tag, "_ready_after_wb"}, 32'(if_ready), 32'd1);
    tick();
`endif
  endtask

  initial begin
    reset    = 1'b1;
    if_valid = 1'b1;
    if_instr = I_ADDI_X1_5;
    if_pc    = 32'h100;
    DoutA    = 32'hAAAA_0001;
    DoutB    = 32'hBBBB_0002;
    wb_we    = 1'b0;
    wb_rw    = '0;
    wb_din   = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;

    // Reset with if_valid high: ID/EX stays empty
    tick();
    tick();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_ex_writes_rd", 32'(ex_writes_rd), 32'd0);
    check("rst_ex_illegal", 32'(ex_illegal), 32'd0);
    reset = 1'b0;

    // ADDI x1,x0,5: one-cycle latency
    present(I_ADDI_X1_5, 32'h100);
    #1;
    check("addi_x1_if_ready", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    check("addi_x1_ex_valid", 32'(ex_valid), 32'd1);
    check("addi_x1_ex_imm", ex_imm, 32'd5);
    check("addi_x1_ex_rd", 32'(ex_rd), 32'd1);
    check("addi_x1_ex_writes_rd", 32'(ex_writes_rd), 32'd1);
    check("addi_x1_rs1_x0", ex_rs1_val, 32'd0);
    check("addi_x1_ex_pc", ex_pc, 32'h100);
    check("addi_x1_ex_opcode", 32'(ex_opcode), 32'h13);
    tick(); // handshake completes, scoreboard[1] set
    check("addi_x1_drained", 32'(ex_valid), 32'd0);

    // ADD x3,x1,x2 blocked by scoreboard[1]
    present(I_ADD_X3, 32'h108);
    #1;
    check("add_x3_ra", 32'(ra), 32'd1);
    check("add_x3_rb", 32'(rb), 32'd2);
    check("add_x3_stall_sb", 32'(if_ready), 32'd0);
    tick();
    check("add_x3_not_taken", 32'(ex_valid), 32'd0);
    wb_release("add_x3", 5'd1, 32'h1234, 1'b0);
    if_valid = 1'b0;
    check("add_x3_ex_valid", 32'(ex_valid), 32'd1);
    check("add_x3_rs1", ex_rs1_val, 32'h1234);
    check("add_x3_rs2", ex_rs2_val, 32'hBBBB_0002);
    check("add_x3_rd", 32'(ex_rd), 32'd3);
    check("add_x3_imm", ex_imm, 32'd0);

    // Backpressure: ID/EX holds ADD x3 for 3 cycles
    ex_ready = 1'b0;
    present(I_BEQ_M8, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d_if_ready", i), 32'(if_ready), 32'd0);
      tick();
      check($sformatf("hold%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("hold%0d_ex_rd", i), 32'(ex_rd), 32'd3);
      check($sformatf("hold%0d_ex_pc", i), ex_pc, 32'h108);
      check($sformatf("hold%0d_rs1", i), ex_rs1_val, 32'h1234);
    end
    ex_ready = 1'b1;
    #1;
    check("beq_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("beq_ex_imm", ex_imm, 32'hFFFF_FFF8);
    check("beq_writes_rd", 32'(ex_writes_rd), 32'd0);
    check("beq_opcode", 32'(ex_opcode), 32'h63);
    check("beq_ex_pc", ex_pc, 32'h200);

    // Illegal opcode
    present(I_ILLEGAL, 32'h204);
    #1;
    check("ill_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("ill_ex_illegal", 32'(ex_illegal), 32'd1);
    check("ill_writes_rd", 32'(ex_writes_rd), 32'd0);
    check("ill_ex_imm", ex_imm, 32'd0);

    // ADDI x5 then ADD x6,x5,x5 (RAW on x5)
    present(I_ADDI_X5_7, 32'h208);
    #1;
    check("addi_x5_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("addi_x5_rd", 32'(ex_rd), 32'd5);
    check("addi_x5_illegal", 32'(ex_illegal), 32'd0);
    present(I_ADD_X6, 32'h20C);
    #1;
    check("add_x6_stall_idex", 32'(if_ready), 32'd0);
    tick();
    #1;
    check("add_x6_stall_sb", 32'(if_ready), 32'd0);
    tick();
    check("add_x6_not_taken", 32'(ex_valid), 32'd0);
    wb_release("add_x6", 5'd5, 32'h55, 1'b1);
    check("add_x6_rs1", ex_rs1_val, 32'h55);
    check("add_x6_rs2", ex_rs2_val, 32'h55);
    check("add_x6_rd", 32'(ex_rd), 32'd6);

    // WAW: ADDI x5 twice
    present(I_ADDI_X5_7, 32'h210);
    #1;
    check("waw1_if_ready", 32'(if_ready), 32'd1);
    tick();
    present(I_ADDI_X5_9, 32'h214);
    #1;
    check("waw2_stall_idex", 32'(if_ready), 32'd0);
    tick();
    #1;
    check("waw2_stall_sb", 32'(if_ready), 32'd0);
    tick();
    wb_we  = 1'b1;
    wb_rw  = 5'd5;
    wb_din = 32'h99;
    #1;
    check("waw2_stall_on_wb", 32'(if_ready), 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    check("waw2_ready_after_wb", 32'(if_ready), 32'd1);
    tick();
    check("waw2_ex_imm", ex_imm, 32'd9);
    check("waw2_ex_pc", ex_pc, 32'h214);

    // rd = x0 never writes
    present(I_ADDI_X0_1, 32'h218);
    #1;
    check("addi_x0_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("addi_x0_writes_rd", 32'(ex_writes_rd), 32'd0);
    check("addi_x0_imm", ex_imm, 32'd1);

    // Flush with ex_valid=1
    if_valid = 1'b0;
    ex_ready = 1'b0;
    tick();
    check("pre_flush_ex_valid", 32'(ex_valid), 32'd1);
    ex_ready = 1'b1;
    flush    = 1'b1;
    present(I_LUI_X7, 32'h300);
    #1;
    check("flush_if_ready", 32'(if_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    present(I_ADD_X8, 32'h304);
    #1;
    check("flush_sb_kept_x3", 32'(if_ready), 32'd0);
    present(I_LUI_X7, 32'h300);
    #1;
    check("lui_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("lui_ex_imm", ex_imm, 32'h1234_5000);
    check("lui_ex_rd", 32'(ex_rd), 32'd7);
    check("lui_ex_opcode", 32'(ex_opcode), 32'h37);

    // Reset together with if_valid and a live ID/EX entry
    reset = 1'b1;
    present(I_ADDI_X1_5, 32'h400);
    tick();
    check("rst2_ex_valid", 32'(ex_valid), 32'd0);
    check("rst2_ex_imm", ex_imm, 32'd0);
    check("rst2_ex_rd", 32'(ex_rd), 32'd0);
    check("rst2_ex_pc", ex_pc, 32'd0);
    check("rst2_ex_opcode", 32'(ex_opcode), 32'd0);
    check("rst2_ex_rs1", ex_rs1_val, 32'd0);
    reset = 1'b0;
    present(I_ADD_X8, 32'h404);
    #1;
    check("rst2_sb_cleared", 32'(if_ready), 32'd1);
    if_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk in 1: sole clock, rising edge.
- reset in 1: synchronous, active-high.
- if_valid in 1, if_ready out 1, if_instr in 32, if_pc in 32: fetch handshake and payload.
- ra out 5, rb out 5: register-file read addresses.
- DoutA in 32, DoutB in 32: register-file asynchronous read data.
- wb_we in 1, wb_rw in 5, wb_din in 32: copy of register-file write port.
- flush in 1: discard decode contents.
- ex_valid out 1, ex_ready in 1: execute handshake.
- ex_pc out 32, ex_rs1_val out 32, ex_rs2_val out 32, ex_imm out 32: execute data payload.
- ex_rd out 5, ex_opcode out 7, ex_funct3 out 3, ex_funct7 out 7: execute decode payload.
- ex_writes_rd out 1, ex_illegal out 1: execute flags.
REQ-002 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 SHALL drive ra=if_instr[19:15] and rb=if_instr[24:20] combinationally every cycle.
REQ-004 SHALL hold one ID/EX register; latency if-accept to ex_valid SHALL be exactly 1 cycle.
REQ-005 if_ready SHALL be (!ex_valid || ex_ready) && !hazard && !flush.
REQ-006 rs1 use: JALR, LOAD, STORE, BRANCH, OP-IMM, OP. rs2 use: STORE, BRANCH, OP.
REQ-007 rd write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, only when rd!=0.
REQ-008 Other opcodes: ex_illegal=1, ex_writes_rd=0, no source use.
REQ-009 A 32-bit scoreboard SHALL set bit rd on an ex handshake (ex_valid&&ex_ready&&ex_writes_rd) and clear bit wb_rw when wb_we=1.
REQ-010 Same-cycle set and clear of one bit: set wins. Bit 0 SHALL stay 0.
REQ-011 hazard=1 if any of:
- a used source is busy in the scoreboard and not bypassed (REQ-013);
- a used source equals a valid ID/EX ex_rd with ex_writes_rd=1;
- the new rd is busy or matches the ID/EX rd (WAW).
REQ-012 Captured operands SHALL come from DoutA/DoutB, except x0, which SHALL read as 0.
REQ-013 Bypass, under DECODE_BYPASS_EN: wb_we && wb_rw==source && source!=0 -> capture wb_din and ignore the scoreboard bit for that source.
REQ-014 ex_imm SHALL be sign-extended per format: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0); R-type and illegal -> 0.
REQ-015 ID/EX payload SHALL hold stable while ex_valid && !ex_ready.
REQ-016 flush SHALL clear ex_valid next cycle and deassert if_ready that cycle; the scoreboard SHALL remain unchanged.

Reset
REQ-017 On reset, ex_valid, the scoreboard and all ex_* payload SHALL be 0.
REQ-018 Reset SHALL override flush and handshakes in the same cycle.

Configuration
REQ-019 With DECODE_BYPASS_EN defined, same-cycle writeback SHALL be bypassed per REQ-013.
REQ-020 Without DECODE_BYPASS_EN, a busy source SHALL stall until the cycle after its scoreboard bit clears; operands SHALL always come from DoutA/DoutB.

Structure
REQ-021 decode_pkg SHALL hold the opcode constants, the immediate-format enum and the XLEN=32 / register-count constants.
REQ-022 Immediate generation SHALL be the sub-module imm_gen (combinational, instr -> imm).

Verification
REQ-023 Reset, then ADDI x1,x0,5 (0x00500093) with ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_writes_rd=1; scoreboard[1] set the following cycle.
REQ-024 ADD x3,x1,x2 while scoreboard[1]=1 and wb_we=0 -> if_ready=0; on wb_we=1, wb_rw=1, wb_din=0x1234 with bypass -> accepted that cycle, ex_rs1_val=0x1234. Without the macro -> accepted one cycle later.
REQ-025 ex_ready=0 for 3 cycles with a valid instruction held -> ex_* stable, if_ready=0; ex_ready=1 -> new instruction accepted the same cycle.
REQ-026 Back-to-back ADDI x5 then ADD x6,x5,x5 -> second stalls until x5 writeback; WAW case ADDI x5 twice -> second stalls.
REQ-027 BEQ with offset -8 -> ex_imm=0xFFFFFFF8, ex_writes_rd=0; opcode 0x7F -> ex_illegal=1.
REQ-028 flush asserted with ex_valid=1 -> ex_valid=0 next cycle, scoreboard unchanged; reset asserted together with if_valid -> all outputs 0.
